// File: rtl/packer_2b_8b_pkg.sv
// Shared widths and types for the 2-bit to 8-bit packer.
// The packer top optionally adds a flush path when PACK_FLUSH_EN is defined.
package packer_2b_8b_pkg;

  localparam int PACK_DATA_W = 2;
  localparam int PACK_LANES  = 4;
  localparam int PACK_OUT_W  = PACK_DATA_W * PACK_LANES;
  localparam int PACK_CNT_W  = 2;

  typedef logic [PACK_LANES-1:0][PACK_DATA_W-1:0] pack_buf_t;

endpackage

// File: rtl/packer_lane_cnt.sv
// Mod-LANES lane counter; wrap flags the increment that completes a word.
// clr has priority over inc so a flush restarts at lane 0.
module packer_lane_cnt
  import packer_2b_8b_pkg::*;
#(
  parameter int LANES = PACK_LANES,
  parameter int CNT_W = PACK_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last = (cnt_q == CNT_W'(LANES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  assign cnt  = cnt_q;
  assign wrap = inc & last;

endmodule

// File: rtl/packer_2b_8b.sv
// Packs four consecutive valid 2-bit words into one byte with a one-cycle strobe.
// Define PACK_FLUSH_EN to add the flush input and out_count output.
module packer_2b_8b
  import packer_2b_8b_pkg::*;
#(
  parameter int DATA_W = PACK_DATA_W,
  parameter int LANES  = PACK_LANES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
`ifdef PACK_FLUSH_EN
  input  logic                      flush,
  output logic [$clog2(LANES+1)-1:0] out_count,
`endif
  output logic [DATA_W*LANES-1:0]   out_data,
  output logic                      out_valid
);

  localparam int OUT_W = DATA_W * LANES;
  localparam int CNT_W = $clog2(LANES);
  localparam int NUM_W = $clog2(LANES + 1);

  logic [CNT_W-1:0]                cnt;
  logic                            wrap;
  logic                            emit;
  logic                            clr;
  logic [LANES-1:0][DATA_W-1:0]    buf_q, buf_d;
  logic [OUT_W-1:0]                out_data_q, out_data_d;
  logic                            out_valid_q;

  packer_lane_cnt #(.LANES(LANES), .CNT_W(CNT_W)) u_lane_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (in_valid),
    .clr   (clr),
    .cnt   (cnt),
    .wrap  (wrap)
  );

`ifdef PACK_FLUSH_EN
  logic [NUM_W-1:0] filled;
  logic [NUM_W-1:0] out_count_q;

  // Lanes occupied once this cycle's word (if any) has been placed.
  assign filled = NUM_W'(cnt) + NUM_W'(in_valid);
  assign emit   = flush ? (filled != '0) : wrap;
  assign clr    = flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    out_count_q <= '0;
    else if (emit) out_count_q <= filled;
  end

  assign out_count = out_count_q;
`else
  assign emit = wrap;
  assign clr  = 1'b0;
`endif

  // Lanes above the fill point are always zero because the buffer clears on emit,
  // so a partial flush needs no extra masking.
  always_comb begin
    buf_d      = buf_q;
    out_data_d = out_data_q;
    if (in_valid) buf_d[cnt] = in_data;
    if (emit) begin
      out_data_d = buf_d;
      buf_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= emit;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_packer_2b_8b.sv
// Randomized and directed bench for packer_2b_8b against a word-queue reference model.
// Compiles with or without PACK_FLUSH_EN.
module tb_packer_2b_8b;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
`ifdef PACK_FLUSH_EN
  logic       flush = 1'b0;
  logic [2:0] out_count;
  logic [2:0] exp_count = '0;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0] words[$];
  logic [7:0] exp_data  = '0;
  logic       exp_valid = 1'b0;

  always #5 clk = ~clk;

  packer_2b_8b dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef PACK_FLUSH_EN
    .flush     (flush),
    .out_count (out_count),
`endif
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Emit whatever the queue holds: word k goes to bits [2k+1:2k], missing lanes are 0.
  task automatic model_emit();
    logic [7:0] w;
    w = '0;
    foreach (words[k]) w = w | (8'(words[k]) << (2 * k));
    exp_data  = w;
    exp_valid = 1'b1;
`ifdef PACK_FLUSH_EN
    exp_count = 3'(words.size());
`endif
    words.delete();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
    chk({tag, ".data"},  32'(out_data),  32'(exp_data));
`ifdef PACK_FLUSH_EN
    chk({tag, ".count"}, 32'(out_count), 32'(exp_count));
`endif
  endtask

  task automatic step(input logic v, input logic [1:0] d, input string tag);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    exp_valid = 1'b0;
    if (v) begin
      words.push_back(d);
      if (words.size() == 4) model_emit();
    end
    #1;
    check_outputs(tag);
  endtask

`ifdef PACK_FLUSH_EN
  task automatic flush_step(input logic v, input logic [1:0] d, input string tag);
    in_valid = v;
    in_data  = d;
    flush    = 1'b1;
    @(posedge clk);
    exp_valid = 1'b0;
    if (v) words.push_back(d);
    if (words.size() != 0) model_emit();
    #1;
    flush = 1'b0;
    check_outputs(tag);
  endtask
`endif

  task automatic do_reset(input int cycles);
    #2;
    reset = 1'b0;
    in_valid = 1'b0;
    words.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
`ifdef PACK_FLUSH_EN
    exp_count = '0;
`endif
    #1;
    check_outputs("rst_async");
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
    check_outputs("rst_hold");
  endtask

  initial begin
    logic [1:0] seq[4];
    int         pulses;
    seq = '{2'b01, 2'b10, 2'b11, 2'b00};

    @(posedge clk);
    do_reset(2);
    chk("reset.data", 32'(out_data), 32'h00);

    // Back-to-back
    foreach (seq[i]) step(1'b1, seq[i], "b2b");
    chk("b2b.value", 32'(out_data), 32'h39);
    chk("b2b.pulse", 32'(out_valid), 32'h1);
    step(1'b0, 2'b00, "b2b_after");
    chk("b2b.single", 32'(out_valid), 32'h0);

    // Gaps between words
    pulses = 0;
    foreach (seq[i]) begin
      step(1'b1, seq[i], "gap");
      if (out_valid) pulses++;
      repeat (i + 1) begin
        step(1'b0, 2'b11, "gap_idle");
        if (out_valid) pulses++;
      end
    end
    chk("gap.pulses", 32'(pulses), 32'd1);
    chk("gap.value", 32'(out_data), 32'h39);

    // Mid-operation reset discards the partial word
    step(1'b1, 2'b01, "mid");
    step(1'b1, 2'b00, "mid");
    do_reset(1);
    repeat (4) step(1'b1, 2'b11, "mid_fill");
    chk("mid.value", 32'(out_data), 32'hFF);

    // Continuous stream
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b10, "stream");
      if (out_valid) pulses++;
      if (i == 3 || i == 7) chk("stream.value", 32'(out_data), 32'hAA);
      if (i == 5) chk("stream.hold", 32'(out_data), 32'hAA);
    end
    chk("stream.pulses", 32'(pulses), 32'd2);

`ifdef PACK_FLUSH_EN
    step(1'b1, 2'b11, "fl");
    step(1'b1, 2'b01, "fl");
    flush_step(1'b0, 2'b00, "flush2");
    chk("flush.value", 32'(out_data), 32'h07);
    chk("flush.count", 32'(out_count), 32'd2);
    flush_step(1'b0, 2'b00, "flush_empty");
    chk("flush.empty", 32'(out_valid), 32'h0);
    repeat (3) step(1'b1, 2'b01, "flw");
    flush_step(1'b1, 2'b10, "flush_wrap");
    chk("flush.wrap_cnt", 32'(out_count), 32'd4);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic [1:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = 2'($urandom);
`ifdef PACK_FLUSH_EN
      if ($urandom_range(0, 9) == 0) flush_step(v, d, "rnd_flush");
      else
`endif
      step(v, d, "rnd");
      if (i == 200) begin
        do_reset(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
